// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch controller: FSM state encoding,
// datapath width and instruction size.
package pc_fetch_ctrl_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      EXEC = 2'd2
   } state_t;

endpackage

// File: rtl/pc_fetch_ctrl_target_adder.sv
// Combinational branch/jump target adder. JALR-style targets have bit 0
// cleared after the add.
import pc_fetch_ctrl_pkg::*;

module pcTargetAdder (
   input  logic [XLEN-1:0] targetBase,
   input  logic [XLEN-1:0] immExt,
   input  logic            pcTargetSrc,
   output logic [XLEN-1:0] targetAddr
);

   logic [XLEN-1:0] sum;

   assign sum        = targetBase + immExt;
   assign targetAddr = {sum[XLEN-1:1], (pcTargetSrc ? 1'b0 : sum[0])};

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller: IDLE -> REQ -> EXEC sequencing, pc update
// and retire counting. Define PC_MISALIGN_TRAP_EN to trap on misaligned taken targets.
import pc_fetch_ctrl_pkg::*;

module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] targetBase,
   input  logic [31:0] immExt,
   input  logic        pcTargetSrc,
   input  logic        pcSrc,
   input  logic        imemReady,
   output logic [31:0] pc,
   output logic [31:0] pcPlus4,
   output logic        imemReq,
   output logic        instrValid,
   output logic        trap,
   output logic [31:0] retireCount,
   output state_t      fsmState
);

   // Handshake: a fetch completes in the cycle where imemReq && imemReady;
   // the instruction then executes (instrValid) in exactly the following cycle.

   state_t      state, stateNext;
   logic [31:0] targetAddr;
   logic [31:0] pcNext;
   logic        takeTrap;

   pcTargetAdder u_target_adder (
      .targetBase  (targetBase),
      .immExt      (immExt),
      .pcTargetSrc (pcTargetSrc),
      .targetAddr  (targetAddr)
   );

   assign pcPlus4  = pc + INSTR_BYTES;
   assign fsmState = state;

   always_comb begin
      stateNext  = state;
      imemReq    = 1'b0;
      instrValid = 1'b0;
      case (state)
         IDLE: stateNext = REQ;
         REQ: begin
            imemReq = 1'b1;
            if (imemReady) stateNext = EXEC;
         end
         EXEC: begin
            instrValid = 1'b1;
            stateNext  = REQ;
         end
         default: stateNext = IDLE;
      endcase
   end

`ifdef PC_MISALIGN_TRAP_EN
   always_comb begin
      takeTrap = pcSrc && (targetAddr[1:0] != 2'b00);
      if (takeTrap)   pcNext = TRAP_VECTOR;
      else if (pcSrc) pcNext = targetAddr;
      else            pcNext = pcPlus4;
   end
`else
   always_comb begin
      takeTrap = 1'b0;
      pcNext   = pcSrc ? {targetAddr[31:2], 2'b00} : pcPlus4;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= RESET_VECTOR;
         retireCount <= 32'd0;
      end else begin
         state <= stateNext;
         if (state == EXEC) begin
            pc <= pcNext;
            if (!takeTrap) retireCount <= retireCount + 32'd1;
         end
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   logic trapQ;

   // Registered so the pulse lines up with the pc load of TRAP_VECTOR.
   always_ff @(posedge clk) begin
      if (reset) trapQ <= 1'b0;
      else       trapQ <= (state == EXEC) && takeTrap;
   end

   assign trap = trapQ;
`else
   assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by
// randomized traffic, checked against a behavioural fetch/execute model.
import pc_fetch_ctrl_pkg::*;

module tb_pc_fetch_ctrl;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;

   logic        clk;
   logic        reset;
   logic [31:0] targetBase;
   logic [31:0] immExt;
   logic        pcTargetSrc;
   logic        pcSrc;
   logic        imemReady;
   logic [31:0] pc;
   logic [31:0] pcPlus4;
   logic        imemReq;
   logic        instrValid;
   logic        trap;
   logic [31:0] retireCount;
   state_t      fsmState;

   int n_vec;
   int n_err;

   // behavioural model
   logic [31:0] m_pc;
   logic [31:0] m_retire;
   bit          m_trap;
   bit          m_idle;
   bit          m_req;
   bit          m_exec;
   bit          m_known;

   pc_fetch_ctrl #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
      .clk         (clk),
      .reset       (reset),
      .targetBase  (targetBase),
      .immExt      (immExt),
      .pcTargetSrc (pcTargetSrc),
      .pcSrc       (pcSrc),
      .imemReady   (imemReady),
      .pc          (pc),
      .pcPlus4     (pcPlus4),
      .imemReq     (imemReq),
      .instrValid  (instrValid),
      .trap        (trap),
      .retireCount (retireCount),
      .fsmState    (fsmState)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit rst, input logic [31:0] b, input logic [31:0] i,
                             input bit pts, input bit src, input bit rdy);
      logic [31:0] t;
      if (rst) begin
         m_pc = RV; m_retire = 0; m_trap = 0;
         m_idle = 1; m_req = 0; m_exec = 0; m_known = 1;
         return;
      end
      m_trap = 0;
      if (m_idle) begin
         m_idle = 0; m_req = 1;
      end else if (m_req) begin
         if (rdy) begin m_req = 0; m_exec = 1; end
      end else if (m_exec) begin
         m_exec = 0; m_req = 1;
         t = b + i;
         if (pts) t = t & 32'hFFFF_FFFE;
         if (src) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (t % 4 != 0) begin
               m_pc = TV; m_trap = 1;
            end else begin
               m_pc = t; m_retire = m_retire + 1;
            end
`else
            m_pc = t - (t % 4);
            m_retire = m_retire + 1;
`endif
         end else begin
            m_pc = m_pc + 4;
            m_retire = m_retire + 1;
         end
      end
   endtask

   function automatic state_t exp_state();
      if (m_req)  return REQ;
      if (m_exec) return EXEC;
      return IDLE;
   endfunction

   // driver: called at a negedge; applies inputs, advances one clock, checks
   task automatic cycle(input bit rst, input logic [31:0] b, input logic [31:0] i,
                        input bit pts, input bit src, input bit rdy);
      reset = rst; targetBase = b; immExt = i;
      pcTargetSrc = pts; pcSrc = src; imemReady = rdy;
      @(posedge clk);
      model_step(rst, b, i, pts, src, rdy);
      @(negedge clk);
      if (m_known) begin
         chk("pc", pc, m_pc);
         chk("pcPlus4", pcPlus4, m_pc + 32'd4);
         chk("imemReq", {31'd0, imemReq}, {31'd0, m_req});
         chk("instrValid", {31'd0, instrValid}, {31'd0, m_exec});
         chk("trap", {31'd0, trap}, {31'd0, m_trap});
         chk("retireCount", retireCount, m_retire);
         chk("state", {30'd0, fsmState}, {30'd0, exp_state()});
      end
   endtask

   task automatic rand_cycle(input bit rst, input bit rdy);
      cycle(rst, $urandom, $urandom_range(15, 0), 1'($urandom_range(1, 0)),
            1'($urandom_range(1, 0)), rdy);
   endtask

   // runs to the EXEC cycle, checks its pc, then executes with the given controls
   task automatic fetch(input logic [31:0] b, input logic [31:0] i, input bit pts,
                        input bit src, input logic [31:0] exp_pc);
      int n;
      n = 0;
      while (!m_exec && n < 8) begin
         rand_cycle(1'b0, 1'b1);
         n++;
      end
      if (!m_exec) begin
         n_vec++; n_err++;
         $display("FAIL fetch_timeout: no EXEC within 8 cycles");
      end
      chk("exec_pc", pc, exp_pc);
      cycle(1'b0, b, i, pts, src, 1'b1);
   endtask

   initial begin
      n_vec = 0; n_err = 0; m_known = 0;
      m_idle = 0; m_req = 0; m_exec = 0; m_trap = 0; m_pc = 0; m_retire = 0;
      reset = 1; targetBase = 0; immExt = 0; pcTargetSrc = 0; pcSrc = 0; imemReady = 0;
      @(negedge clk);

      // reset state
      rand_cycle(1'b1, 1'b1);
      rand_cycle(1'b1, 1'b0);
      chk("rst_pc", pc, RV);
      chk("rst_imemReq", {31'd0, imemReq}, 32'd0);
      chk("rst_instrValid", {31'd0, instrValid}, 32'd0);

      // three sequential fetches
      fetch(32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      fetch(32'h0, 32'h0, 1'b0, 1'b0, 32'h4);
      fetch(32'h0, 32'h0, 1'b0, 1'b0, 32'h8);
      chk("s1_retire", retireCount, 32'd3);

      // memory stall in REQ
      for (int k = 0; k < 5; k++) begin
         rand_cycle(1'b0, 1'b0);
         chk("s2_imemReq", {31'd0, imemReq}, 32'd1);
         chk("s2_pc", pc, 32'hC);
         chk("s2_retire", retireCount, 32'd3);
      end

      // JALR-style target with bit 0 cleared
      fetch(32'h1001, 32'h4, 1'b1, 1'b1, 32'hC);
      chk("s3_pc", pc, 32'h1004);
      chk("s3_trap", {31'd0, trap}, 32'd0);

      // misaligned taken target
      fetch(32'h100, 32'h2, 1'b0, 1'b1, 32'h1004);
      chk("s4_pc", pc, 32'h100);
`ifdef PC_MISALIGN_TRAP_EN
      chk("s4_trap", {31'd0, trap}, 32'd1);
      chk("s4_retire", retireCount, 32'd4);
`else
      chk("s4_trap", {31'd0, trap}, 32'd0);
      chk("s4_retire", retireCount, 32'd5);
`endif

      // pc + 4 wrap
      fetch(32'hFFFF_FFF0, 32'hC, 1'b0, 1'b1, 32'h100);
      chk("s5_pc_top", pc, 32'hFFFF_FFFC);
      fetch(32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFC);
      chk("s5_pc_wrap", pc, 32'h0);
      chk("s5_trap", {31'd0, trap}, 32'd0);

      // reset during a taken EXEC
      fetch(32'h40, 32'h0, 1'b0, 1'b1, 32'h0);
      rand_cycle(1'b0, 1'b1);
      if (!m_exec) rand_cycle(1'b0, 1'b1);
      cycle(1'b1, 32'h200, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("s6_pc", pc, RV);
      chk("s6_state", {30'd0, fsmState}, {30'd0, IDLE});
      chk("s6_retire", retireCount, 32'd0);

      // randomized traffic
      for (int k = 0; k < 400; k++)
         rand_cycle(($urandom_range(49, 0) == 0), 1'($urandom_range(1, 0)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
